pixel_row_feeder: RTL and testbench

Upstream stage of `CHIP`. Accepts a raster-order stream of 5-bit pixels, one per beat, and buffers two image rows in line buffers. Emits one vertical column triplet per beat on `pixel_out0/1/2`, plus `load_end` on the last triplet of the frame. These outputs connect directly to `CHIP`'s `pixel_in0/1/2`. A per-frame `mode` is latched at frame start and presented steadily to `CHIP`.

---
 rtl/feeder_pkg.sv | 20 ++
 rtl/line_buffer.sv | 51 +++++
 rtl/pixel_row_feeder.sv | 178 +++++++++++++++++
 tb/tb_pixel_row_feeder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// ---------------------------------------------------------------------------
// feeder_pkg
// Shared definitions for pixel_row_feeder and its line buffers:
//   - feeder_state_t : frame sequencing FSM states
//   - DEF_IMG_W / DEF_IMG_H / DEF_PIX_W : default frame geometry and pixel width
// ---------------------------------------------------------------------------
package feeder_pkg;

  localparam int DEF_IMG_W = 102;
  localparam int DEF_IMG_H = 102;
  localparam int DEF_PIX_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Fixed-length delay line of DEPTH entries built as a circular buffer.
// dout is the value written DEPTH shifts ago (the oldest entry); on a shift
// that entry is overwritten by din and the pointer moves on.
// Ports:
//   clk      in  : clock, rising edge
//   reset    in  : synchronous active-low reset (clears the pointer only)
//   shift_en in  : advance the delay line by one entry
//   din      in  : WIDTH-bit value entering the line
//   dout     out : WIDTH-bit value leaving the line
// ---------------------------------------------------------------------------
module line_buffer
  import feeder_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (shift_en) begin
      ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
    end
  end

  // Contents need no reset: the feeder never emits a triplet until both
  // lines have been refilled with the current frame.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[ptr_reg] <= din;
    end
  end

  // The slot about to be overwritten holds the oldest sample.
  assign dout = mem[ptr_reg];

endmodule

// File: rtl/pixel_row_feeder.sv
// ---------------------------------------------------------------------------
// pixel_row_feeder
// Accepts a raster-order pixel stream, keeps the two previous rows in line
// buffers and emits one vertical column triplet per beat once row 2 is
// reached. load_end marks the final triplet of a frame; mode_in is latched
// into mode_out at frame start.
//
// Optional feature: define FEEDER_PAD_EN to accept only the
// (IMG_W-2)x(IMG_H-2) interior and synthesize the zero border internally.
//
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : synchronous active-low reset
//   mode_in    in  : frame mode, sampled on the frame-start beat
//   in_valid   in  : in_pixel valid
//   in_pixel   in  : PIX_W-bit input pixel, raster order
//   in_ready   out : pixel accepted this cycle when in_valid is also high
//   mode_out   out : latched frame mode
//   out_valid  out : triplet valid
//   pixel_out0 out : pixel at (r-2, c)
//   pixel_out1 out : pixel at (r-1, c)
//   pixel_out2 out : pixel at (r, c)
//   load_end   out : pulse with the final triplet of the frame
//   busy       out : FSM not idle
// ---------------------------------------------------------------------------
module pixel_row_feeder
  import feeder_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_in,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  output logic             mode_out,
  output logic             out_valid,
  output logic [PIX_W-1:0] pixel_out0,
  output logic [PIX_W-1:0] pixel_out1,
  output logic [PIX_W-1:0] pixel_out2,
  output logic             load_end,
  output logic             busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  feeder_state_t state_reg, state_next;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;

  logic             out_valid_reg;
  logic             load_end_reg;
  logic             mode_reg;
  logic [PIX_W-1:0] pix0_reg, pix1_reg, pix2_reg;

  logic             advance;     // one raster position enters the pipeline
  logic [PIX_W-1:0] beat_pixel;  // pixel value for that position
  logic [PIX_W-1:0] lb0_tap, lb1_tap;
  logic             row_end, fill_end, frame_end, emit;

  assign row_end   = (col_reg == COL_LAST);
  assign fill_end  = row_end && (row_reg == ROW_ONE);
  assign frame_end = row_end && (row_reg == ROW_LAST);
  assign emit      = advance && (row_reg >= ROW_TWO);

`ifdef FEEDER_PAD_EN
  logic border;
  logic active;

  assign border = (row_reg == '0) || (row_reg == ROW_LAST) ||
                  (col_reg == '0) || (col_reg == COL_LAST);
  assign active = (state_reg == FILL) || (state_reg == STREAM);

  // Border positions never take input; they run freely once a frame is
  // under way. In IDLE an in_valid only kicks off border (0,0).
  assign in_ready   = reset && active && !border;
  assign advance    = reset && (((state_reg == IDLE) && in_valid) ||
                                (active && (border || in_valid)));
  assign beat_pixel = border ? '0 : in_pixel;
`else
  assign in_ready   = reset && (state_reg != DONE);
  assign advance    = in_valid && in_ready;
  assign beat_pixel = in_pixel;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:   if (advance) state_next = FILL;
      FILL:   if (advance && fill_end) state_next = STREAM;
      STREAM: if (advance && frame_end) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- Raster position ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (advance) begin
      if (row_end) begin
        col_reg <= '0;
        row_reg <= frame_end ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // ---------------- Line buffers ----------------
  // lb1 delays the stream by one row; lb0 delays lb1's output by another.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (advance),
    .din      (beat_pixel),
    .dout     (lb1_tap)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (advance),
    .din      (lb1_tap),
    .dout     (lb0_tap)
  );

  // ---------------- Output registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      load_end_reg  <= 1'b0;
      mode_reg      <= 1'b0;
      pix0_reg      <= '0;
      pix1_reg      <= '0;
      pix2_reg      <= '0;
    end else begin
      out_valid_reg <= emit;
      load_end_reg  <= advance && frame_end;
      if (emit) begin
        pix0_reg <= lb0_tap;
        pix1_reg <= lb1_tap;
        pix2_reg <= beat_pixel;
      end
      if ((state_reg == IDLE) && advance) begin
        mode_reg <= mode_in;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign load_end   = load_end_reg;
  assign mode_out   = mode_reg;
  assign pixel_out0 = pix0_reg;
  assign pixel_out1 = pix1_reg;
  assign pixel_out2 = pix2_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_pixel_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_pixel_row_feeder
// Directed bench for pixel_row_feeder on a 4x4 frame of 5-bit pixels.
// Each task drives one scenario and checks the DUT inline.
// ---------------------------------------------------------------------------
module tb_pixel_row_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mode_in = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          in_ready;
  logic          mode_out;
  logic          out_valid;
  logic [PW-1:0] pixel_out0, pixel_out1, pixel_out2;
  logic          load_end;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  // Last valid triplet the DUT should still be presenting.
  logic [PW-1:0] hold0 = '0, hold1 = '0, hold2 = '0;

  pixel_row_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_in    (mode_in),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .mode_out   (mode_out),
    .out_valid  (out_valid),
    .pixel_out0 (pixel_out0),
    .pixel_out1 (pixel_out1),
    .pixel_out2 (pixel_out2),
    .load_end   (load_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset(input logic idle_ready);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({out_valid, load_end, busy, mode_out, in_ready} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got v/le/busy/mode/rdy=%b required 00000",
               {out_valid, load_end, busy, mode_out, in_ready});
    end
    compared++;
    if ({pixel_out0, pixel_out1, pixel_out2} !== '0) begin
      mismatched++;
      $display("FAIL reset_pixels: got (%0d,%0d,%0d) required (0,0,0)",
               pixel_out0, pixel_out1, pixel_out2);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (in_ready !== idle_ready || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: got rdy=%b busy=%b required rdy=%b busy=0",
               in_ready, busy, idle_ready);
    end
    hold0 = '0; hold1 = '0; hold2 = '0;
    $display("test_reset done");
  endtask

  // Continuous frame base..base+15 with full per-beat checking.
  task automatic test_basic(input int base, input string tag);
    logic exp_v;
    for (int k = 0; k < W * H; k++) begin
      in_valid = 1'b1;
      in_pixel = PW'(base + k);
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL %s_ready k=%0d: got %b required 1", tag, k, in_ready);
      end
      @(posedge clk);
      #1;
      exp_v = (k >= 2 * W);
      compared++;
      if (out_valid !== exp_v || load_end !== (k == W * H - 1)) begin
        mismatched++;
        $display("FAIL %s_valid k=%0d: got v=%b le=%b required v=%b le=%b",
                 tag, k, out_valid, load_end, exp_v, (k == W * H - 1));
      end
      if (exp_v) begin
        hold0 = PW'(base + k - 2 * W);
        hold1 = PW'(base + k - W);
        hold2 = PW'(base + k);
      end
      compared++;
      if (pixel_out0 !== hold0 || pixel_out1 !== hold1 || pixel_out2 !== hold2) begin
        mismatched++;
        $display("FAIL %s_triplet k=%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 tag, k, pixel_out0, pixel_out1, pixel_out2, hold0, hold1, hold2);
      end
    end
    in_valid = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_done: got rdy=%b busy=%b required rdy=0 busy=1", tag, in_ready, busy);
    end
    @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || load_end !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_idle: got busy=%b v=%b le=%b required 0 0 0", tag, busy, out_valid, load_end);
    end
    $display("%s frame base=%0d done", tag, base);
  endtask

  task automatic test_stalls();
    for (int k = 0; k < W * H; k++) begin
      in_valid = 1'b1;
      in_pixel = PW'(k);
      @(posedge clk);
      #1;
      if (k >= 2 * W) begin
        hold0 = PW'(k - 2 * W);
        hold1 = PW'(k - W);
        hold2 = PW'(k);
      end
      compared++;
      if (out_valid !== (k >= 2 * W) || pixel_out0 !== hold0 ||
          pixel_out1 !== hold1 || pixel_out2 !== hold2) begin
        mismatched++;
        $display("FAIL stall_beat k=%0d: got v=%b (%0d,%0d,%0d) required v=%b (%0d,%0d,%0d)",
                 k, out_valid, pixel_out0, pixel_out1, pixel_out2,
                 (k >= 2 * W), hold0, hold1, hold2);
      end
      in_valid = 1'b0;
      in_pixel = 5'h1f;
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0 || load_end !== 1'b0 || pixel_out0 !== hold0 ||
          pixel_out1 !== hold1 || pixel_out2 !== hold2) begin
        mismatched++;
        $display("FAIL stall_gap k=%0d: got v=%b le=%b (%0d,%0d,%0d) required v=0 le=0 (%0d,%0d,%0d)",
                 k, out_valid, load_end, pixel_out0, pixel_out1, pixel_out2, hold0, hold1, hold2);
      end
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_end_busy: got %b required 0", busy);
    end
    $display("test_stalls done");
  endtask

  task automatic test_mode();
    for (int k = 0; k < W * H; k++) begin
      in_valid = 1'b1;
      in_pixel = PW'(k);
      mode_in  = (k % 2 == 0);
      @(posedge clk);
      #1;
      compared++;
      if (mode_out !== 1'b1) begin
        mismatched++;
        $display("FAIL mode_latch k=%0d: got %b required 1", k, mode_out);
      end
    end
    hold0 = PW'(7); hold1 = PW'(11); hold2 = PW'(15);
    in_valid = 1'b0;
    mode_in  = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (mode_out !== 1'b1) begin
      mismatched++;
      $display("FAIL mode_after_frame: got %b required 1", mode_out);
    end
    $display("test_mode done");
  endtask

  task automatic test_back_to_back();
    mode_in = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < W * H; k++) begin
        in_valid = 1'b1;
        in_pixel = PW'(16 * f + k);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_ready f=%0d k=%0d: got %b required 1", f, k, in_ready);
        end
        @(posedge clk);
        #1;
        if (k >= 2 * W) begin
          compared++;
          if (out_valid !== 1'b1 || pixel_out0 !== PW'(16 * f + k - 8) ||
              pixel_out1 !== PW'(16 * f + k - 4) || pixel_out2 !== PW'(16 * f + k)) begin
            mismatched++;
            $display("FAIL b2b_triplet f=%0d k=%0d: got v=%b (%0d,%0d,%0d) required v=1 (%0d,%0d,%0d)",
                     f, k, out_valid, pixel_out0, pixel_out1, pixel_out2,
                     16 * f + k - 8, 16 * f + k - 4, 16 * f + k);
          end
        end
      end
      // DONE cycle: the next frame's first pixel is presented but refused.
      in_valid = (f == 0);
      in_pixel = PW'(16);
      #1;
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_dead f=%0d: got rdy=%b required 0", f, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    hold0 = PW'(23); hold1 = PW'(27); hold2 = PW'(31);
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_pixel = PW'(k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, load_end, busy, mode_out, in_ready} !== 5'b0 ||
        {pixel_out0, pixel_out1, pixel_out2} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got v/le/busy/mode/rdy=%b pix=(%0d,%0d,%0d) required all 0",
               {out_valid, load_end, busy, mode_out, in_ready}, pixel_out0, pixel_out1, pixel_out2);
    end
    reset = 1'b1;
    hold0 = '0; hold1 = '0; hold2 = '0;
    test_basic(0, "restart");
    $display("test_reset_mid done");
  endtask

  task automatic test_padding();
    logic [PW-1:0] interior [4];
    logic [3*PW-1:0] exp_tr [8];
    int sent;
    int got;
    logic acc;
    interior[0] = 5'd1; interior[1] = 5'd2; interior[2] = 5'd3; interior[3] = 5'd4;
    exp_tr[0] = {5'd0, 5'd0, 5'd0};
    exp_tr[1] = {5'd0, 5'd1, 5'd3};
    exp_tr[2] = {5'd0, 5'd2, 5'd4};
    exp_tr[3] = {5'd0, 5'd0, 5'd0};
    exp_tr[4] = {5'd0, 5'd0, 5'd0};
    exp_tr[5] = {5'd1, 5'd3, 5'd0};
    exp_tr[6] = {5'd2, 5'd4, 5'd0};
    exp_tr[7] = {5'd0, 5'd0, 5'd0};
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid = (sent < 4);
      in_pixel = (sent < 4) ? interior[sent] : 5'h1f;
      #1;
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (out_valid) begin
        compared++;
        if ({pixel_out0, pixel_out1, pixel_out2} !== exp_tr[got] || load_end !== (got == 7)) begin
          mismatched++;
          $display("FAIL pad_triplet n=%0d: got (%0d,%0d,%0d) le=%b required %h le=%b",
                   got, pixel_out0, pixel_out1, pixel_out2, load_end, exp_tr[got], (got == 7));
        end
        got++;
      end
    end
    in_valid = 1'b0;
    compared++;
    if (got != 8 || sent != 4) begin
      mismatched++;
      $display("FAIL pad_count: got %0d triplets / %0d inputs required 8 / 4", got, sent);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("test_padding done");
  endtask

  initial begin
`ifdef FEEDER_PAD_EN
    test_reset(1'b0);
    test_padding();
`else
    test_reset(1'b1);
    test_basic(0, "basic");
    test_stalls();
    test_mode();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
